// File: rtl/bus_slave_timer_pkg.sv
// Shared definitions for the bus slave timer and its bus interface.
// Provides register offsets, control/status bit positions, the bus word width,
// active-low signal levels, interface FSM state encodings and the captured
// request record.
package bus_slave_timer_pkg;

    localparam int BUS_WORD_W = 32;

    // Register offsets (slave address bits [1:0])
    localparam logic [1:0] TIMER_ADDR_CTRL  = 2'd0;
    localparam logic [1:0] TIMER_ADDR_INTR  = 2'd1;
    localparam logic [1:0] TIMER_ADDR_EXPR  = 2'd2;
    localparam logic [1:0] TIMER_ADDR_COUNT = 2'd3;

    // Bit positions
    localparam int TIMER_START_LOC    = 0;
    localparam int TIMER_PERIODIC_LOC = 1;
    localparam int TIMER_FLAG_LOC     = 0;

    // Levels for active-low bus signals
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Bus interface FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Access captured at the accepting strobe
    typedef struct packed {
        logic                  rw;
        logic [1:0]            addr;
        logic [BUS_WORD_W-1:0] data;
    } bus_req_t;

endpackage

// File: rtl/bus_slave_if.sv
// Generic bus slave protocol engine: accepts a strobe in IDLE, inserts
// WAIT_CYCLES wait states, then pulses rdy_ low for one cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cs_, as_, rw, addr, wr_data   bus request inputs
//   wr_en, wr_addr, wr_word       write commit (valid on the edge entering RESP)
//   rd_en, rd_addr                read response select (valid while in RESP)
//   rdy_                          active-low ready pulse
module bus_slave_if
    import bus_slave_timer_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_,
    input  logic                  as_,
    input  logic                  rw,
    input  logic [1:0]            addr,
    input  logic [BUS_WORD_W-1:0] wr_data,
    output logic                  wr_en,
    output logic [1:0]            wr_addr,
    output logic [BUS_WORD_W-1:0] wr_word,
    output logic                  rd_en,
    output logic [1:0]            rd_addr,
    output logic                  rdy_
);

    localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    logic [1:0] state_reg, state_next;
    logic [3:0] wait_cnt_reg, wait_cnt_next;
    bus_req_t   req_reg;
    bus_req_t   live_req;
    bus_req_t   cur_req;
    logic       accept;

    assign accept   = (state_reg == ST_IDLE) && (cs_ == ENABLE_) && (as_ == ENABLE_);
    assign live_req = '{rw: rw, addr: addr, data: wr_data};

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next    = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    wait_cnt_next = 4'd0;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = ST_RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
            req_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (accept) begin
                req_reg <= live_req;
            end
        end
    end

    // With no wait states the commit edge is the accepting edge itself, so
    // the request comes straight from the bus rather than the capture register.
    assign cur_req = (state_reg == ST_IDLE) ? live_req : req_reg;
    assign wr_en   = (state_next == ST_RESP) && (state_reg != ST_RESP) && !cur_req.rw;
    assign wr_addr = cur_req.addr;
    assign wr_word = cur_req.data;

    assign rd_en   = (state_reg == ST_RESP) && req_reg.rw;
    assign rd_addr = req_reg.addr;
    assign rdy_    = (state_reg == ST_RESP) ? ENABLE_ : DISABLE_;

endmodule

// File: rtl/bus_slave_timer.sv
// Memory-mapped 32-bit interval timer bus slave.
// Registers: 0 CTRL (START, PERIODIC), 1 INTR (FLAG), 2 EXPR, 3 COUNT.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cs_, as_          active-low chip select / address strobe
//   rw, addr, wr_data access direction, register select, write data
//   rd_data           read data, nonzero only during the rdy_ pulse of a read
//   rdy_              active-low one-cycle ready
//   irq               level interrupt (FLAG)
module bus_slave_timer
    import bus_slave_timer_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_,
    input  logic                  as_,
    input  logic                  rw,
    input  logic [1:0]            addr,
    input  logic [BUS_WORD_W-1:0] wr_data,
    output logic [BUS_WORD_W-1:0] rd_data,
    output logic                  rdy_,
    output logic                  irq
);

    logic                  wr_en;
    logic [1:0]            wr_addr;
    logic [BUS_WORD_W-1:0] wr_word;
    logic                  rd_en;
    logic [1:0]            rd_addr;

    logic                  start_reg;
    logic                  periodic_reg;
    logic                  flag_reg;
    logic [BUS_WORD_W-1:0] expr_reg;
    logic [BUS_WORD_W-1:0] count_reg;
    logic                  expire;
    logic [BUS_WORD_W-1:0] rd_word;

    bus_slave_if #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_if (
        .clk     (clk),
        .reset   (reset),
        .cs_     (cs_),
        .as_     (as_),
        .rw      (rw),
        .addr    (addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_word (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rdy_    (rdy_)
    );

    assign expire = start_reg && (count_reg == expr_reg);

    // Timer update first, bus write afterwards so a colliding write to
    // COUNT or CTRL overrides it; FLAG is the exception (set beats clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            start_reg    <= 1'b0;
            periodic_reg <= 1'b0;
            flag_reg     <= 1'b0;
            expr_reg     <= '0;
            count_reg    <= '0;
        end else begin
            if (start_reg) begin
                if (expire) begin
                    count_reg <= '0;
                    flag_reg  <= 1'b1;
                    start_reg <= periodic_reg;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end
            if (wr_en) begin
                case (wr_addr)
                    TIMER_ADDR_CTRL: begin
                        start_reg    <= wr_word[TIMER_START_LOC];
                        periodic_reg <= wr_word[TIMER_PERIODIC_LOC];
                    end
                    TIMER_ADDR_INTR:  flag_reg  <= wr_word[TIMER_FLAG_LOC] | expire;
                    TIMER_ADDR_EXPR:  expr_reg  <= wr_word;
                    TIMER_ADDR_COUNT: count_reg <= wr_word;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd_addr)
            TIMER_ADDR_CTRL: begin
                rd_word[TIMER_START_LOC]    = start_reg;
                rd_word[TIMER_PERIODIC_LOC] = periodic_reg;
            end
            TIMER_ADDR_INTR:  rd_word[TIMER_FLAG_LOC] = flag_reg;
            TIMER_ADDR_EXPR:  rd_word = expr_reg;
            TIMER_ADDR_COUNT: rd_word = count_reg;
            default:          rd_word = '0;
        endcase
    end

    assign rd_data = rd_en ? rd_word : '0;
    assign irq     = flag_reg;

endmodule
